// File: rtl/alu_regfile.sv
// alu_regfile: ALU operand register file with post-reset zeroing sweep and sticky overflow
module alu_regfile #(
    parameter int WORDSIZE = 64,
    parameter int REGCOUNT = 32,
    parameter int ADDRW    = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDRW-1:0]    rs1_addr,
    input  logic [ADDRW-1:0]    rs2_addr,
    output logic [WORDSIZE-1:0] operand_a,
    output logic [WORDSIZE-1:0] operand_b,
    input  logic                rd_wr_en,
    input  logic [ADDRW-1:0]    rd_addr,
    input  logic [WORDSIZE-1:0] rd_data,
    input  logic                ovf_in,
    input  logic                ovf_clear,
    output logic                ovf_sticky,
    output logic                ready
);
    typedef enum logic {INIT, RUN} state_t;
    state_t state, state_nx;
    logic [ADDRW-1:0] init_idx, idx_nx, waddr;
    logic [WORDSIZE-1:0] wdata;
    logic [WORDSIZE-1:0] regs [REGCOUNT];
    logic ovf_nx, we;
    // next state, sweep counter, single write port mux and sticky update
    always_comb begin
        state_nx = state;
        idx_nx   = init_idx;
        ovf_nx   = ovf_sticky;
        we       = 1'b0;
        waddr    = init_idx;
        wdata    = '0;
        if (state == INIT) begin
            we     = 1'b1;
            idx_nx = init_idx + 1'b1;
            if (init_idx == ADDRW'(REGCOUNT - 1)) begin
                idx_nx   = '0;
                state_nx = RUN;
            end
        end else begin
            we     = rd_wr_en && (rd_addr != '0);
            waddr  = rd_addr;
            wdata  = rd_data;
            ovf_nx = (ovf_sticky & ~ovf_clear) | (rd_wr_en & ovf_in);
        end
    end
    // control state; reset restarts the sweep from x1
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= INIT;
            init_idx   <= ADDRW'(1);
            ovf_sticky <= 1'b0;
        end else begin
            state      <= state_nx;
            init_idx   <= idx_nx;
            ovf_sticky <= ovf_nx;
        end
    end
    // storage array without reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (we && !reset) regs[waddr] <= wdata;
    end
    assign ready = (state == RUN);
    assign operand_a = (!ready || rs1_addr == '0) ? '0 :
                       (rd_wr_en && rd_addr == rs1_addr) ? rd_data : regs[rs1_addr];
    assign operand_b = (!ready || rs2_addr == '0) ? '0 :
                       (rd_wr_en && rd_addr == rs2_addr) ? rd_data : regs[rs2_addr];
endmodule

// File: tb/tb_alu_regfile.sv
// tb_alu_regfile: table vectors, reset sequences and randomized checks against a reference model
module tb_alu_regfile;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [63:0] operand_a, operand_b, rd_data;
    logic        rd_wr_en, ovf_in, ovf_clear, ovf_sticky, ready;

    int total = 0;
    int bad = 0;

    logic [63:0] m_reg [32];
    logic        m_ready = 1'b0;
    logic        m_sticky = 1'b0;
    int          m_cnt = 0;

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic        wr;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic        oi, oc;
        logic [63:0] ea, eb;
        logic        es;
    } vec_t;

    localparam logic [63:0] C = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] F = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] D = 64'hDEAD;
    localparam logic [63:0] N = 64'h99;

    alu_regfile dut (
        .clk(clk), .reset(reset), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .operand_a(operand_a), .operand_b(operand_b), .rd_wr_en(rd_wr_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .ovf_in(ovf_in),
        .ovf_clear(ovf_clear), .ovf_sticky(ovf_sticky), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_rd(input logic [4:0] a);
        if (!m_ready || a == 5'd0) return 64'd0;
        if (rd_wr_en && rd_addr == a) return rd_data;
        return m_reg[a];
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_ready = 1'b0;
            m_cnt = 0;
            m_sticky = 1'b0;
            for (int i = 0; i < 32; i++) m_reg[i] = 64'd0;
        end else if (!m_ready) begin
            m_cnt++;
            if (m_cnt == 31) m_ready = 1'b1;
        end else begin
            if (rd_wr_en && rd_addr != 5'd0) m_reg[rd_addr] = rd_data;
            m_sticky = (m_sticky & ~ovf_clear) | (rd_wr_en & ovf_in);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; rd_wr_en = 1'b0; rd_addr = 5'd0; rd_data = 64'd0;
        ovf_in = 1'b0; ovf_clear = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    endtask

    task automatic chk_model(input string n);
        chk({n, "_a"}, operand_a, exp_rd(rs1_addr));
        chk({n, "_b"}, operand_b, exp_rd(rs2_addr));
        chk({n, "_sticky"}, {63'd0, ovf_sticky}, {63'd0, m_sticky});
        chk({n, "_ready"}, {63'd0, ready}, {63'd0, m_ready});
    endtask

    vec_t vt [12];

    initial begin
        vt = '{
            '{5, 5, 1, 5, C, 0, 0, C, C, 0},
            '{5, 5, 0, 0, 0, 0, 0, C, C, 0},
            '{6, 0, 1, 0, F, 0, 0, 0, 0, 0},
            '{0, 5, 0, 0, 0, 0, 0, 0, C, 0},
            '{6, 7, 1, 7, D, 0, 0, 0, D, 0},
            '{7, 7, 1, 0, 1, 1, 0, D, D, 0},
            '{7, 5, 0, 0, 0, 0, 1, D, C, 1},
            '{9, 0, 1, 9, N, 1, 1, N, 0, 0},
            '{9, 3, 0, 0, 0, 1, 0, N, 0, 1},
            '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1},
            '{0, 9, 0, 0, 0, 1, 0, 0, N, 0},
            '{9, 9, 0, 0, 0, 0, 0, N, N, 0}
        };
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 31; i++) begin
            chk("init_ready", {63'd0, ready}, 64'd0);
            tick();
        end
        chk("init_done_ready", {63'd0, ready}, 64'd1);
        chk("init_sticky", {63'd0, ovf_sticky}, 64'd0);
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            #1;
            chk("init_zero_a", operand_a, 64'd0);
            chk("init_zero_b", operand_b, 64'd0);
        end
        for (int i = 0; i < 12; i++) begin
            rs1_addr = vt[i].rs1; rs2_addr = vt[i].rs2; rd_wr_en = vt[i].wr;
            rd_addr = vt[i].wa; rd_data = vt[i].wd; ovf_in = vt[i].oi; ovf_clear = vt[i].oc;
            #1;
            chk($sformatf("vec%0d_a", i), operand_a, vt[i].ea);
            chk($sformatf("vec%0d_b", i), operand_b, vt[i].eb);
            chk($sformatf("vec%0d_sticky", i), {63'd0, ovf_sticky}, {63'd0, vt[i].es});
            tick();
        end
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 149) == 0);
            rd_wr_en = $urandom_range(0, 1);
            rd_addr = 5'($urandom_range(0, 31));
            rd_data = {$urandom, $urandom};
            ovf_in = ($urandom_range(0, 2) == 0);
            ovf_clear = ($urandom_range(0, 3) == 0);
            rs1_addr = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom_range(0, 31));
            rs2_addr = ($urandom_range(0, 3) == 0) ? rs1_addr : 5'($urandom_range(0, 31));
            #1;
            chk_model("rand");
            tick();
        end
        idle();
        while (!m_ready) tick();
        rd_wr_en = 1'b1; rd_addr = 5'd3; rd_data = 64'h55;
        tick();
        idle();
        rs1_addr = 5'd3;
        #1;
        chk("x3_written", operand_a, 64'h55);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd_wr_en = 1'b1; rd_addr = 5'd4; rd_data = 64'h77; ovf_in = 1'b1;
        rs1_addr = 5'd4; rs2_addr = 5'd3;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("init1_a", operand_a, 64'd0);
            chk("init1_ready", {63'd0, ready}, 64'd0);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 31; i++) begin
            #1;
            chk("init2_ready", {63'd0, ready}, 64'd0);
            chk("init2_b", operand_b, 64'd0);
            tick();
        end
        idle();
        rs1_addr = 5'd3; rs2_addr = 5'd4;
        #1;
        chk("reinit_ready", {63'd0, ready}, 64'd1);
        chk("reinit_x3", operand_a, 64'd0);
        chk("reinit_x4", operand_b, 64'd0);
        chk("reinit_sticky", {63'd0, ovf_sticky}, 64'd0);
        chk_model("reinit_model");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
